control_reloj_hms: RTL and testbench
====================================

// Module: control_reloj_hms
// PURPOSE
//  Time-of-day controller sequencing three cascaded modulo counters (seconds mod 60, minutes mod 60, hours mod 24).
//  Drives them from a clock-cycle prescaler.
//  Provides a button-driven set-time state machine.
//  Sits between the debounced push-button front end and the 7-segment display decoder of the clock design.
// PARAMETERS
//  CLK_PER_SEG  50_000_000  clock cycles per second; prescaler counts 0..CLK_PER_SEG-1 (width = clogb2(CLK_PER_SEG-1))
// PORTS
//  clock      in   1  system clock, all state on rising edge
//  reset      in   1  asynchronous, active-high; clears all state
//  enable     in   1  run enable; low freezes prescaler and time in RUN
//  btn_modo   in   1  one-cycle pulse (already debounced): advance FSM state
//  btn_inc    in   1  one-cycle pulse: increment selected field in set states
//  segundos   out  6  seconds 0..59
//  minutos    out  6  minutes 0..59
//  horas      out  5  hours 0..23
//  tick_seg   out  1  one-cycle pulse, prescaler terminal count in RUN with enable
//  fin_dia    out  1  one-cycle pulse coincident with tick_seg at 23:59:59
//  estado     out  3  FSM state code, drives display blinking
//  alarma     out  1  alarm active (constant 0 without ALARMA_EN)
// BEHAVIOUR
//  Reset: segundos=minutos=horas=0, prescaler=0, estado=RUN(0), alarma=0, tick_seg=fin_dia=0.
//  FSM codes: RUN=0, SET_H=1, SET_M=2, SET_S=3 (+ SET_AH=4, SET_AM=5 with ALARMA_EN).
//  btn_modo transitions: RUN->SET_H->SET_M->SET_S->RUN (SET_S->SET_AH->SET_AM->RUN with ALARMA_EN).
//  Transitions take effect on the next edge.
//  Prescaler:
//   - Advances only in RUN with enable=1.
//   - tick_seg = (prescaler==CLK_PER_SEG-1) && RUN && enable; combinational from registered state.
//   - Prescaler wraps to 0 on that edge.
//  Cascade on tick_seg edge:
//   - seg 59->0 carries to min; min 59->0 carries to hour; hour 23->0.
//   - 23:59:59 -> 00:00:00 in a single edge, with fin_dia=1 during the tick cycle.
//  Set states:
//   - Prescaler and cascade frozen; tick_seg=0; enable ignored.
//   - SET_H: btn_inc hour+1 (23->0, no carry).
//   - SET_M: btn_inc minute+1 (59->0, no carry into hours).
//   - SET_S: btn_inc clears segundos to 0.
//  Exit to RUN: prescaler forced to 0, so the first tick_seg occurs exactly CLK_PER_SEG cycles after entering RUN.
//  Simultaneous btn_modo and btn_inc: btn_modo wins; btn_inc dropped.
//  btn_inc in RUN: no effect on time (silences alarm, see CONFIGURATION).
//  enable low mid-second: prescaler holds its value; counting resumes from it.
//  Reset mid-operation (any state, any prescaler value): immediate return to reset values; no tick emitted.
// CONFIGURATION
//  ALARMA_EN defined:
//   - Adds alarm registers al_h(5b)/al_m(6b), reset 0.
//   - Adds states SET_AH/SET_AM; btn_inc increments al_h / al_m with the same wrap rules as SET_H / SET_M.
//   - alarma=1 in RUN while horas==al_h && minutos==al_m and not silenced.
//   - btn_inc in RUN sets silence; silence clears when minutos changes.
//   - alarma forced 0 in all set states.
//  ALARMA_EN undefined:
//   - No alarm registers or states; SET_S->RUN.
//   - alarma tied to 0; btn_inc in RUN ignored.
// TESTING (sim with CLK_PER_SEG=4)
//  1. reset=1 then 0, enable=1 -> tick_seg every 4th cycle; segundos 0->1 on edge after first tick; all outputs 0 during reset.
//  2. Preload 23:59:58 via SET states, RUN 8 cycles -> 23:59:59 then 00:00:00; fin_dia pulses exactly once with the second tick.
//  3. From RUN: modo, inc x25 in SET_H -> horas=1; modo, inc x60 in SET_M -> minutos=0, horas unchanged.
//  4. btn_modo and btn_inc in the same cycle in SET_H -> estado=SET_M, horas unchanged.
//  5. enable=0 for 10 cycles at prescaler=2 -> no tick, time frozen; first tick 1 cycle after enable=1. Reset asserted mid-second -> all zero immediately.
//  6. [ALARMA_EN] al=00:01, run to 00:01:00 -> alarma=1; btn_inc -> alarma=0 next cycle and stays 0 until minutos=2.

Source files
------------

// File: rtl/control_reloj_hms.sv
// Time-of-day controller: prescaler, hh:mm:ss cascade and button set-time FSM.
// Optional alarm (al_h/al_m, SET_AH/SET_AM states) built when ALARMA_EN is defined.
module control_reloj_hms #(
    parameter int CLK_PER_SEG = 50_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       btn_modo,
    input  logic       btn_inc,
    output logic [5:0] segundos,
    output logic [5:0] minutos,
    output logic [4:0] horas,
    output logic       tick_seg,
    output logic       fin_dia,
    output logic [2:0] estado,
    output logic       alarma
);

    localparam int PW = (CLK_PER_SEG > 2) ? $clog2(CLK_PER_SEG) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_PER_SEG - 1);

    localparam logic [2:0] S_RUN   = 3'd0;
    localparam logic [2:0] S_SET_H = 3'd1;
    localparam logic [2:0] S_SET_M = 3'd2;
    localparam logic [2:0] S_SET_S = 3'd3;
`ifdef ALARMA_EN
    localparam logic [2:0] S_SET_AH = 3'd4;
    localparam logic [2:0] S_SET_AM = 3'd5;
`endif

    logic [2:0]    st_q, st_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [5:0]    s_q, s_d;
    logic [5:0]    m_q, m_d;
    logic [4:0]    h_q, h_d;
    logic          run, tick, inc_ok;

    assign run    = (st_q == S_RUN);
    assign tick   = run && enable && (pre_q == PRE_LAST);
    assign inc_ok = btn_inc && !btn_modo;

    always_comb begin
        st_d  = st_q;
        pre_d = pre_q;
        s_d   = s_q;
        m_d   = m_q;
        h_d   = h_q;
        if (run && enable) begin
            pre_d = tick ? '0 : pre_q + 1'b1;
        end
        if (tick) begin
            if (s_q == 6'd59) begin
                s_d = '0;
                if (m_q == 6'd59) begin
                    m_d = '0;
                    h_d = (h_q == 5'd23) ? 5'd0 : h_q + 5'd1;
                end else begin
                    m_d = m_q + 6'd1;
                end
            end else begin
                s_d = s_q + 6'd1;
            end
        end
        if (btn_modo) begin
            unique case (st_q)
                S_RUN:    st_d = S_SET_H;
                S_SET_H:  st_d = S_SET_M;
                S_SET_M:  st_d = S_SET_S;
`ifdef ALARMA_EN
                S_SET_S:  st_d = S_SET_AH;
                S_SET_AH: st_d = S_SET_AM;
`endif
                default:  st_d = S_RUN;
            endcase
            // Restart the second cleanly when returning to RUN
            if (!run && st_d == S_RUN) begin
                pre_d = '0;
            end
        end else if (btn_inc) begin
            unique case (st_q)
                S_SET_H: h_d = (h_q == 5'd23) ? 5'd0 : h_q + 5'd1;
                S_SET_M: m_d = (m_q == 6'd59) ? 6'd0 : m_q + 6'd1;
                S_SET_S: s_d = '0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st_q  <= S_RUN;
            pre_q <= '0;
            s_q   <= '0;
            m_q   <= '0;
            h_q   <= '0;
        end else begin
            st_q  <= st_d;
            pre_q <= pre_d;
            s_q   <= s_d;
            m_q   <= m_d;
            h_q   <= h_d;
        end
    end

`ifdef ALARMA_EN
    logic [4:0] al_h_q, al_h_d;
    logic [5:0] al_m_q, al_m_d;
    logic       sil_q, sil_d;

    always_comb begin
        al_h_d = al_h_q;
        al_m_d = al_m_q;
        sil_d  = sil_q;
        if (inc_ok && st_q == S_SET_AH) begin
            al_h_d = (al_h_q == 5'd23) ? 5'd0 : al_h_q + 5'd1;
        end
        if (inc_ok && st_q == S_SET_AM) begin
            al_m_d = (al_m_q == 6'd59) ? 6'd0 : al_m_q + 6'd1;
        end
        // Silence starts set so 00:00 after reset does not ring an unset alarm
        if (inc_ok && run) begin
            sil_d = 1'b1;
        end else if (m_d != m_q) begin
            sil_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            al_h_q <= '0;
            al_m_q <= '0;
            sil_q  <= 1'b1;
        end else begin
            al_h_q <= al_h_d;
            al_m_q <= al_m_d;
            sil_q  <= sil_d;
        end
    end

    assign alarma = run && !sil_q && (h_q == al_h_q) && (m_q == al_m_q);
`else
    logic unused_inc;
    assign unused_inc = inc_ok;
    assign alarma     = 1'b0;
`endif

    assign segundos = s_q;
    assign minutos  = m_q;
    assign horas    = h_q;
    assign tick_seg = tick;
    assign fin_dia  = tick && (h_q == 5'd23) && (m_q == 6'd59) && (s_q == 6'd59);
    assign estado   = st_q;

endmodule

// File: tb/tb_control_reloj_hms.sv
// Directed bench for control_reloj_hms with CLK_PER_SEG=4.
// Alarm scenario compiled only when ALARMA_EN is defined.
module tb_control_reloj_hms;

    logic       clk = 1'b0;
    logic       reset, enable, btn_modo, btn_inc;
    logic [5:0] segundos, minutos;
    logic [4:0] horas;
    logic       tick_seg, fin_dia, alarma;
    logic [2:0] estado;
    int         total = 0;
    int         bad = 0;

    control_reloj_hms #(.CLK_PER_SEG(4)) dut (
        .clock(clk), .reset(reset), .enable(enable),
        .btn_modo(btn_modo), .btn_inc(btn_inc),
        .segundos(segundos), .minutos(minutos), .horas(horas),
        .tick_seg(tick_seg), .fin_dia(fin_dia),
        .estado(estado), .alarma(alarma)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic modo();
        btn_modo = 1'b1;
        cyc(1);
        btn_modo = 1'b0;
    endtask

    task automatic inc(input int n);
        for (int k = 0; k < n; k++) begin
            btn_inc = 1'b1;
            cyc(1);
            btn_inc = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1;
        cyc(2);
        total++;
        if ({segundos, minutos, horas, tick_seg, fin_dia, estado, alarma} !== 23'd0) begin
            $display("FAIL reset_outputs got=%h exp=0",
                     {segundos, minutos, horas, tick_seg, fin_dia, estado, alarma});
            bad++;
        end
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (tick_seg !== (i % 4 == 3)) begin
                $display("FAIL tick_cadence[%0d] got=%0b exp=%0b", i, tick_seg, (i % 4 == 3));
                bad++;
            end
            total++;
            if (segundos !== 6'(i / 4)) begin
                $display("FAIL sec_count[%0d] got=%0d exp=%0d", i, segundos, i / 4);
                bad++;
            end
            cyc(1);
        end
    endtask

    task automatic test_rollover();
        int fins;
        do_reset();
        enable = 1'b1;
        cyc(58 * 4);
        enable = 1'b0;
        modo();
        inc(23);
        modo();
        inc(59);
        modo();
        modo();
        total++;
        if ({estado, horas, minutos, segundos} !== {3'd0, 5'd23, 6'd59, 6'd58}) begin
            $display("FAIL preload got=%0d %0d:%0d:%0d exp=0 23:59:58",
                     estado, horas, minutos, segundos);
            bad++;
        end
        enable = 1'b1;
        fins = 0;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (fin_dia !== (i == 7)) begin
                $display("FAIL fin_dia[%0d] got=%0b exp=%0b", i, fin_dia, (i == 7));
                bad++;
            end
            if (fin_dia) fins++;
            cyc(1);
            if (i == 3) begin
                total++;
                if ({horas, minutos, segundos} !== {5'd23, 6'd59, 6'd59}) begin
                    $display("FAIL pre_midnight got=%0d:%0d:%0d exp=23:59:59",
                             horas, minutos, segundos);
                    bad++;
                end
            end
        end
        total++;
        if ({horas, minutos, segundos} !== 17'd0 || fins != 1) begin
            $display("FAIL midnight got=%0d:%0d:%0d fins=%0d exp=0:0:0 fins=1",
                     horas, minutos, segundos, fins);
            bad++;
        end
    endtask

    task automatic test_set_wrap();
        do_reset();
        enable = 1'b1;
        cyc(22);
        modo();
        total++;
        if (estado !== 3'd1 || tick_seg !== 1'b0) begin
            $display("FAIL enter_set_h got=%0d tick=%0b exp=1 tick=0", estado, tick_seg);
            bad++;
        end
        inc(25);
        total++;
        if (horas !== 5'd1 || segundos !== 6'd5) begin
            $display("FAIL hour_wrap got=%0d s=%0d exp=1 s=5", horas, segundos);
            bad++;
        end
        modo();
        inc(60);
        total++;
        if ({estado, minutos, horas} !== {3'd2, 6'd0, 5'd1}) begin
            $display("FAIL min_wrap got=%0d m=%0d h=%0d exp=2 m=0 h=1", estado, minutos, horas);
            bad++;
        end
        modo();
        inc(1);
        total++;
        if (estado !== 3'd3 || segundos !== 6'd0) begin
            $display("FAIL sec_clear got=%0d s=%0d exp=3 s=0", estado, segundos);
            bad++;
        end
        modo();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (estado !== 3'd0 || tick_seg !== (i == 3)) begin
                $display("FAIL rerun_tick[%0d] got=%0d/%0b exp=0/%0b", i, estado, tick_seg, (i == 3));
                bad++;
            end
            cyc(1);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        enable = 1'b0;
        inc(1);
        total++;
        if ({horas, minutos, segundos} !== 17'd0) begin
            $display("FAIL inc_in_run got=%0d:%0d:%0d exp=0:0:0", horas, minutos, segundos);
            bad++;
        end
        modo();
        btn_modo = 1'b1; btn_inc = 1'b1;
        cyc(1);
        btn_modo = 1'b0; btn_inc = 1'b0;
        total++;
        if (estado !== 3'd2 || horas !== 5'd0) begin
            $display("FAIL modo_wins got=%0d h=%0d exp=2 h=0", estado, horas);
            bad++;
        end
    endtask

    task automatic test_enable_reset();
        do_reset();
        enable = 1'b1;
        cyc(2);
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            total++;
            if (tick_seg !== 1'b0 || segundos !== 6'd0) begin
                $display("FAIL frozen[%0d] got=%0b s=%0d exp=0 s=0", i, tick_seg, segundos);
                bad++;
            end
            cyc(1);
        end
        enable = 1'b1;
        #1;
        total++;
        if (tick_seg !== 1'b0) begin
            $display("FAIL resume_early got=%0b exp=0", tick_seg);
            bad++;
        end
        cyc(1);
        total++;
        if (tick_seg !== 1'b1) begin
            $display("FAIL resume_tick got=%0b exp=1", tick_seg);
            bad++;
        end
        cyc(1);
        total++;
        if (segundos !== 6'd1) begin
            $display("FAIL resume_sec got=%0d exp=1", segundos);
            bad++;
        end
        cyc(2);
        reset = 1'b1;
        #1;
        total++;
        if ({segundos, minutos, horas, tick_seg, fin_dia, estado, alarma} !== 23'd0) begin
            $display("FAIL async_reset got=%h exp=0",
                     {segundos, minutos, horas, tick_seg, fin_dia, estado, alarma});
            bad++;
        end
        cyc(1);
        reset = 1'b0;
    endtask

`ifdef ALARMA_EN
    task automatic test_alarm();
        do_reset();
        enable = 1'b0;
        modo(); modo(); modo(); modo();
        total++;
        if (estado !== 3'd4) begin
            $display("FAIL set_ah_state got=%0d exp=4", estado);
            bad++;
        end
        modo();
        inc(1);
        modo();
        total++;
        if (estado !== 3'd0 || alarma !== 1'b0) begin
            $display("FAIL alarm_armed got=%0d/%0b exp=0/0", estado, alarma);
            bad++;
        end
        enable = 1'b1;
        cyc(240);
        total++;
        if (minutos !== 6'd1 || alarma !== 1'b1) begin
            $display("FAIL alarm_ring got=m%0d a=%0b exp=m1 a=1", minutos, alarma);
            bad++;
        end
        inc(1);
        total++;
        if (alarma !== 1'b0) begin
            $display("FAIL alarm_silence got=%0b exp=0", alarma);
            bad++;
        end
        cyc(238);
        total++;
        if (minutos !== 6'd1 || alarma !== 1'b0) begin
            $display("FAIL alarm_quiet got=m%0d a=%0b exp=m1 a=0", minutos, alarma);
            bad++;
        end
        cyc(1);
        total++;
        if (minutos !== 6'd2 || alarma !== 1'b0) begin
            $display("FAIL alarm_next_min got=m%0d a=%0b exp=m2 a=0", minutos, alarma);
            bad++;
        end
    endtask
`endif

    initial begin
        reset = 1'b1; enable = 1'b0; btn_modo = 1'b0; btn_inc = 1'b0;
        #2;
        test_reset();
        test_rollover();
        test_set_wrap();
        test_simultaneous();
        test_enable_reset();
`ifdef ALARMA_EN
        test_alarm();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
